gcbp_line_gen_multi: RTL and testbench

Parametrised bit-plane line generator for the video stabilisation front end. It sits on the luma tap of the video-to-RAM line buffer and extracts a selectable plane from each pixel: either the raw bit or the Gray-code bit-plane (GCBP). For every active sub-image window in a line it assembles the extracted bits into one BRAM-width word. The word is presented to the sub-image BRAM writer through a valid/ready handshake, with overflow detection.

---
 rtl/gcbp_line_gen_multi.sv | 231 +++++++++++++++++++++++
 tb/tb_gcbp_line_gen_multi.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gcbp_line_gen_multi.sv
// gcbp_line_gen_multi
// Bit-plane line generator for the stabilisation front end. Extracts one
// plane (raw bit, or Gray-code bit-plane when GCBP_GRAY_CODE_EN is defined)
// from each luma pixel, collects the bits of every sub-image window of a line
// into a C_SUBIMAGE_WIDTH-bit word and hands it to the BRAM writer through a
// valid/ready register. A word that completes while the previous one is
// still unaccepted is discarded and flagged (o_drop pulse, sticky o_overflow).
//
// Optional feature macro: GCBP_GRAY_CODE_EN (undefined = raw bit-plane).
// Requires C_SUBIMAGE_WIDTH >= 2.

module gcbp_line_gen_multi #(
  parameter int C_SUBIMAGE_WIDTH    = 128,
  parameter int C_NUM_SUBIMAGES     = 4,
  parameter int C_PIXELS_PER_LINE   = 720,
  parameter int C_EDGE_GAP          = 41,
  parameter int C_INNER_GAP         = 42,
  parameter int C_LUMA_WIDTH        = 9,
  parameter int C_CNT_BITS          = 10,
  parameter int C_IDX_BITS          = 2,
  parameter int C_DEFAULT_BIT_PLANE = 5
) (
  input  logic                        i_clk,
  input  logic                        i_resetn,
  input  logic [C_LUMA_WIDTH-1:0]     i_luma_data,
  input  logic                        i_luma_data_valid,
  input  logic                        i_new_line,
  input  logic [3:0]                  i_bit_plane,
  output logic [C_SUBIMAGE_WIDTH-1:0] o_gcbp_line,
  output logic                        o_gcbp_line_valid,
  input  logic                        i_gcbp_line_ready,
  output logic [C_IDX_BITS-1:0]       o_hori_subimage_cnt,
  output logic                        o_drop,
  output logic                        o_overflow
);

  // Distance between the first pixels of two adjacent windows.
  localparam int STRIDE  = C_SUBIMAGE_WIDTH + C_INNER_GAP;
  // Width of the in-window bit counter (0 .. C_SUBIMAGE_WIDTH-1).
  localparam int BC_BITS = (C_SUBIMAGE_WIDTH > 1) ? $clog2(C_SUBIMAGE_WIDTH) : 1;

  localparam logic [1:0] S_GAP     = 2'd0;
  localparam logic [1:0] S_CAPTURE = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;

  // Plane extraction. Luma is padded with a zero above its MSB so the top
  // plane in Gray mode degenerates to the raw MSB, and a plane index at or
  // beyond the luma width matches no bit and yields constant 0.
  function automatic logic extract_bit(input logic [C_LUMA_WIDTH-1:0] luma,
                                       input logic [3:0]              k);
    logic [C_LUMA_WIDTH:0] ext;
    logic                  b;
    ext = {1'b0, luma};
    b   = 1'b0;
    for (int i = 0; i < C_LUMA_WIDTH; i++) begin
      if (k == 4'(i)) begin
`ifdef GCBP_GRAY_CODE_EN
        b = ext[i] ^ ext[i+1];
`else
        b = ext[i];
`endif
      end else begin
        b = b;
      end
    end
    return b;
  endfunction

  // Line-position and capture state.
  logic [1:0]                  state_r;
  logic [C_CNT_BITS-1:0]       pix_cnt_r;
  logic [C_CNT_BITS-1:0]       start_r;
  logic [C_IDX_BITS-1:0]       idx_r;
  logic [BC_BITS-1:0]          bit_cnt_r;
  logic [C_SUBIMAGE_WIDTH-1:0] shift_r;
  logic [3:0]                  plane_r;

  // Output register.
  logic [C_SUBIMAGE_WIDTH-1:0] out_line_r;
  logic                        out_valid_r;
  logic [C_IDX_BITS-1:0]       out_idx_r;
  logic                        drop_r;
  logic                        overflow_r;

  // Next-state signals.
  logic [1:0]                  state_s;
  logic [C_CNT_BITS-1:0]       start_s;
  logic [C_IDX_BITS-1:0]       idx_s;
  logic [BC_BITS-1:0]          bit_cnt_s;
  logic [C_SUBIMAGE_WIDTH-1:0] shift_s;

  logic                        pixel_ok_s;
  logic                        plane_bit_s;
  logic [C_SUBIMAGE_WIDTH-1:0] shift_in_s;
  logic                        complete_s;
  logic                        transfer_s;

  // A pixel counts only when valid, not overridden by a line start and not
  // past the end of the active line.
  assign pixel_ok_s  = i_luma_data_valid & ~i_new_line &
                       (pix_cnt_r < C_CNT_BITS'(C_PIXELS_PER_LINE));
  assign plane_bit_s = extract_bit(i_luma_data, plane_r);
  // New bits enter at the LSB, so the first window pixel ends up at the MSB.
  assign shift_in_s  = {shift_r[C_SUBIMAGE_WIDTH-2:0], plane_bit_s};
  assign transfer_s  = out_valid_r & i_gcbp_line_ready;

  // Window FSM: find the next window start, shift its pixels, flag completion.
  always_comb begin
    state_s    = state_r;
    start_s    = start_r;
    idx_s      = idx_r;
    bit_cnt_s  = bit_cnt_r;
    shift_s    = shift_r;
    complete_s = 1'b0;
    if (i_new_line) begin
      state_s   = S_GAP;
      start_s   = C_CNT_BITS'(C_EDGE_GAP);
      idx_s     = {C_IDX_BITS{1'b0}};
      bit_cnt_s = {BC_BITS{1'b0}};
      shift_s   = {C_SUBIMAGE_WIDTH{1'b0}};
    end else begin
      case (state_r)
        S_GAP: begin
          if (pixel_ok_s && (pix_cnt_r == start_r)) begin
            shift_s   = shift_in_s;
            bit_cnt_s = BC_BITS'(1);
            state_s   = S_CAPTURE;
          end else begin
            state_s   = S_GAP;
          end
        end
        S_CAPTURE: begin
          if (pixel_ok_s) begin
            shift_s = shift_in_s;
            if (bit_cnt_r == BC_BITS'(C_SUBIMAGE_WIDTH - 1)) begin
              complete_s = 1'b1;
              bit_cnt_s  = {BC_BITS{1'b0}};
              if (idx_r == C_IDX_BITS'(C_NUM_SUBIMAGES - 1)) begin
                state_s = S_DONE;
              end else begin
                idx_s   = idx_r + C_IDX_BITS'(1);
                start_s = start_r + C_CNT_BITS'(STRIDE);
                state_s = S_GAP;
              end
            end else begin
              bit_cnt_s = bit_cnt_r + BC_BITS'(1);
            end
          end else begin
            state_s = S_CAPTURE;
          end
        end
        S_DONE: begin
          state_s = S_DONE;
        end
        default: begin
          state_s = S_GAP;
        end
      endcase
    end
  end

  // Register the window FSM, its window bookkeeping and the shift register.
  always_ff @(posedge i_clk or posedge i_resetn) begin
    if (i_resetn) begin
      state_r   <= S_GAP;
      start_r   <= C_CNT_BITS'(C_EDGE_GAP);
      idx_r     <= {C_IDX_BITS{1'b0}};
      bit_cnt_r <= {BC_BITS{1'b0}};
      shift_r   <= {C_SUBIMAGE_WIDTH{1'b0}};
    end else begin
      state_r   <= state_s;
      start_r   <= start_s;
      idx_r     <= idx_s;
      bit_cnt_r <= bit_cnt_s;
      shift_r   <= shift_s;
    end
  end

  // Pixel position within the line, saturating at the line length.
  always_ff @(posedge i_clk or posedge i_resetn) begin
    if (i_resetn) begin
      pix_cnt_r <= {C_CNT_BITS{1'b0}};
    end else if (i_new_line) begin
      pix_cnt_r <= {C_CNT_BITS{1'b0}};
    end else if (pixel_ok_s) begin
      pix_cnt_r <= pix_cnt_r + C_CNT_BITS'(1);
    end
  end

  // Active bit plane, only changed at a line start so a line is homogeneous.
  always_ff @(posedge i_clk or posedge i_resetn) begin
    if (i_resetn) begin
      plane_r <= 4'(C_DEFAULT_BIT_PLANE);
    end else if (i_new_line) begin
      plane_r <= i_bit_plane;
    end
  end

  // Output handshake: load completed words, drop them when still blocked.
  always_ff @(posedge i_clk or posedge i_resetn) begin
    if (i_resetn) begin
      out_line_r  <= {C_SUBIMAGE_WIDTH{1'b0}};
      out_valid_r <= 1'b0;
      out_idx_r   <= {C_IDX_BITS{1'b0}};
      drop_r      <= 1'b0;
      overflow_r  <= 1'b0;
    end else begin
      drop_r <= 1'b0;
      if (complete_s) begin
        if (!out_valid_r || transfer_s) begin
          out_line_r  <= shift_in_s;
          out_idx_r   <= idx_r;
          out_valid_r <= 1'b1;
        end else begin
          // The pending word has priority; the new one is lost.
          drop_r     <= 1'b1;
          overflow_r <= 1'b1;
        end
      end else if (transfer_s) begin
        out_valid_r <= 1'b0;
      end
    end
  end

  assign o_gcbp_line         = out_line_r;
  assign o_gcbp_line_valid   = out_valid_r;
  assign o_hori_subimage_cnt = out_idx_r;
  assign o_drop              = drop_r;
  assign o_overflow          = overflow_r;

endmodule

// File: tb/tb_gcbp_line_gen_multi.sv
// Self-checking bench for gcbp_line_gen_multi (default parameters).
// A behavioural model built from the window arithmetic predicts completed
// words; they are queued when the model loads them and compared when the DUT
// hands a word over. drop/overflow/valid are compared every cycle.

module tb_gcbp_line_gen_multi;

  localparam int W   = 128;
  localparam int N   = 4;
  localparam int PIX = 720;
  localparam int EG  = 41;
  localparam int IG  = 42;
  localparam int LW  = 9;

  logic           clk = 1'b0;
  logic           rst;
  logic [LW-1:0]  i_luma_data;
  logic           i_luma_data_valid;
  logic           i_new_line;
  logic [3:0]     i_bit_plane;
  logic [W-1:0]   o_gcbp_line;
  logic           o_gcbp_line_valid;
  logic           i_gcbp_line_ready;
  logic [1:0]     o_hori_subimage_cnt;
  logic           o_drop;
  logic           o_overflow;

  gcbp_line_gen_multi dut (
    .i_clk               (clk),
    .i_resetn            (rst),
    .i_luma_data         (i_luma_data),
    .i_luma_data_valid   (i_luma_data_valid),
    .i_new_line          (i_new_line),
    .i_bit_plane         (i_bit_plane),
    .o_gcbp_line         (o_gcbp_line),
    .o_gcbp_line_valid   (o_gcbp_line_valid),
    .i_gcbp_line_ready   (i_gcbp_line_ready),
    .o_hori_subimage_cnt (o_hori_subimage_cnt),
    .o_drop              (o_drop),
    .o_overflow          (o_overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int words_seen = 0;

  // Scoreboard.
  logic [W-1:0] sb_word[$];
  logic [1:0]   sb_idx[$];

  // Model state.
  int           m_cnt;
  int           m_plane;
  logic [W-1:0] m_bits;
  logic         m_valid;
  logic         m_drop;
  logic         m_overflow;

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic model_bit(input logic [LW-1:0] luma, input int k);
    logic [LW-1:0] t;
    logic [LW-1:0] u;
    if (k >= LW) return 1'b0;
    t = luma >> k;
`ifdef GCBP_GRAY_CODE_EN
    if (k == LW - 1) return t[0];
    u = luma >> (k + 1);
    return t[0] ^ u[0];
`else
    u = '0;
    return t[0] ^ u[0];
`endif
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_plane = 5; m_bits = '0;
    m_valid = 1'b0; m_drop = 1'b0; m_overflow = 1'b0;
    sb_word.delete(); sb_idx.delete();
  endtask

  // Predict the effect of the coming clock edge.
  task automatic model_edge(input logic v, input logic [LW-1:0] luma, input logic nl,
                            input logic [3:0] pl, input logic rdy);
    logic        transfer;
    logic        complete;
    logic [1:0]  cidx;
    int          p;
    int          st;
    transfer = m_valid && rdy;
    complete = 1'b0;
    cidx     = 2'd0;
    if (nl) begin
      m_cnt = 0; m_plane = int'(pl); m_bits = '0;
    end else if (v && m_cnt < PIX) begin
      p = m_cnt;
      m_cnt++;
      for (int s = 0; s < N; s++) begin
        st = EG + s * (W + IG);
        if (p >= st && p <= st + W - 1) begin
          m_bits = {m_bits[W-2:0], model_bit(luma, m_plane)};
          if (p == st + W - 1) begin
            complete = 1'b1;
            cidx     = 2'(s);
          end
        end
      end
    end
    m_drop = 1'b0;
    if (complete) begin
      if (!m_valid || transfer) begin
        sb_word.push_back(m_bits);
        sb_idx.push_back(cidx);
        m_valid = 1'b1;
      end else begin
        m_drop = 1'b1;
        m_overflow = 1'b1;
      end
    end else if (transfer) begin
      m_valid = 1'b0;
    end
  endtask

  // One clock cycle; called right after a falling edge.
  task automatic step(input logic v, input logic [LW-1:0] luma, input logic nl,
                      input logic [3:0] pl, input logic rdy);
    i_luma_data_valid = v;
    i_luma_data       = luma;
    i_new_line        = nl;
    i_bit_plane       = pl;
    i_gcbp_line_ready = rdy;
    #1;
    if (o_gcbp_line_valid && rdy) begin
      words_seen++;
      if (sb_word.size() == 0) begin
        check_eq("unexpected_word", {{(W-1){1'b0}}, 1'b1}, '0);
      end else begin
        check_eq("word", o_gcbp_line, sb_word.pop_front());
        check_eq("index", {126'b0, o_hori_subimage_cnt}, {126'b0, sb_idx.pop_front()});
      end
    end
    model_edge(v, luma, nl, pl, rdy);
    @(posedge clk);
    #1;
    check_eq("valid", {127'b0, o_gcbp_line_valid}, {127'b0, m_valid});
    check_eq("drop", {127'b0, o_drop}, {127'b0, m_drop});
    check_eq("overflow", {127'b0, o_overflow}, {127'b0, m_overflow});
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 4'd0, rdy);
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_line"}, o_gcbp_line, '0);
    check_eq({tag, "_valid"}, {127'b0, o_gcbp_line_valid}, '0);
    check_eq({tag, "_cnt"}, {126'b0, o_hori_subimage_cnt}, '0);
    check_eq({tag, "_drop"}, {127'b0, o_drop}, '0);
    check_eq({tag, "_ovf"}, {127'b0, o_overflow}, '0);
  endtask

  initial begin
    rst = 1'b1;
    i_luma_data = '0; i_luma_data_valid = 1'b0; i_new_line = 1'b0;
    i_bit_plane = 4'd0; i_gcbp_line_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs_zero("reset");
    #2 rst = 1'b0;
    @(negedge clk);

    // Line 1: luma = p, plane 5, consumer always ready.
    words_seen = 0;
    step(1'b0, '0, 1'b1, 4'd5, 1'b1);
    for (int p = 0; p < PIX; p++) step(1'b1, LW'(p), 1'b0, 4'd5, 1'b1);
    idle(4, 1'b1);
    check_eq("line1_words", 128'(words_seen), 128'd4);

    // Constant luma lines.
    step(1'b0, '0, 1'b1, 4'd5, 1'b1);
    for (int p = 0; p < PIX; p++) step(1'b1, 9'h060, 1'b0, 4'd5, 1'b1);
    idle(4, 1'b1);
    step(1'b0, '0, 1'b1, 4'd5, 1'b1);
    for (int p = 0; p < PIX; p++) step(1'b1, 9'h020, 1'b0, 4'd5, 1'b1);
    idle(4, 1'b1);

    // Backpressure across a whole line, then release.
    words_seen = 0;
    step(1'b0, '0, 1'b1, 4'd2, 1'b0);
    for (int p = 0; p < PIX; p++) step(1'b1, LW'($urandom), 1'b0, 4'd2, 1'b0);
    idle(3, 1'b0);
    check_eq("bp_overflow", {127'b0, o_overflow}, 128'd1);
    idle(4, 1'b1);
    check_eq("bp_words", 128'(words_seen), 128'd1);

    // 50% random valid, luma a function of pixel position.
    words_seen = 0;
    step(1'b0, '0, 1'b1, 4'd4, 1'b1);
    for (int i = 0; i < 4000 && m_cnt < PIX; i++) begin
      if ($urandom_range(0, 1) == 1) step(1'b1, LW'(m_cnt ^ 9'h1a5), 1'b0, 4'd4, 1'b1);
      else step(1'b0, LW'($urandom), 1'b0, 4'd4, 1'b1);
    end
    idle(4, 1'b1);
    check_eq("rand_words", 128'(words_seen), 128'd4);

    // Line aborted at p = 100, restart with plane 3, 800 valid pixels.
    step(1'b0, '0, 1'b1, 4'd5, 1'b1);
    for (int p = 0; p < 100; p++) step(1'b1, LW'(p), 1'b0, 4'd5, 1'b1);
    words_seen = 0;
    step(1'b1, 9'h1ff, 1'b1, 4'd3, 1'b1);
    for (int p = 0; p < 800; p++) step(1'b1, LW'(p * 3), 1'b0, 4'd7, 1'b1);
    idle(4, 1'b1);
    check_eq("abort_words", 128'(words_seen), 128'd4);

    // Async reset mid-capture with a word pending.
    step(1'b0, '0, 1'b1, 4'd3, 1'b0);
    for (int p = 0; p < 260; p++) step(1'b1, LW'(p), 1'b0, 4'd3, 1'b0);
    check_eq("pre_reset_valid", {127'b0, o_gcbp_line_valid}, 128'd1);
    i_luma_data_valid = 1'b1;
    #2 rst = 1'b1;
    #1;
    check_outputs_zero("async_reset");
    model_reset();
    i_luma_data_valid = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    // No line start: plane must be back at the default.
    words_seen = 0;
    for (int p = 0; p < PIX; p++) step(1'b1, LW'(p), 1'b0, 4'd3, 1'b1);
    idle(4, 1'b1);
    check_eq("post_reset_words", 128'(words_seen), 128'd4);
    check_eq("sb_drained", 128'(sb_word.size()), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
